// File: rtl/threewire_slave_ctrl_pkg.sv
// Shared definitions for the 3-wire bus: FSM state encoding, idle levels of
// the bus wires, timing constants and small constant helper functions.
package threewire_slave_ctrl_pkg;

    typedef enum logic [2:0] {
        TW_IDLE       = 3'd0,
        TW_RW         = 3'd1,
        TW_ADDR       = 3'd2,
        TW_WR_DATA    = 3'd3,
        TW_TURNAROUND = 3'd4,
        TW_RD_DATA    = 3'd5,
        TW_DONE       = 3'd6
    } tw_state_t;

    // Minimum ratio between the system clock and the bus clock.
    localparam int   TW_MIN_CLK_RATIO = 8;

    // Levels the synchronizers assume while reset is asserted.
    localparam logic TW_CLOCK_IDLE = 1'b0;
    localparam logic TW_CS_IDLE    = 1'b1;
    localparam logic TW_DATA_IDLE  = 1'b0;

    // Value of the first frame bit that selects a write.
    localparam logic TW_BIT_WRITE  = 1'b1;

    function automatic int tw_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int tw_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/threewire_sync_edge.sv
// Two-flop synchronizer with a third history flop for edge detection.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   raw       : asynchronous input
//   sync      : synchronized level
//   rise/fall : one-cycle pulses on synchronized rising / falling edges
module threewire_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic rise,
    output logic fall
);

    // [0] metastability flop, [1] synchronized level, [2] previous level
    logic [2:0] pipe_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_reg <= {3{RESET_VAL}};
        end else begin
            pipe_reg <= {pipe_reg[1:0], raw};
        end
    end

    assign sync = pipe_reg[1];
    assign rise = pipe_reg[1] & ~pipe_reg[2];
    assign fall = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/threewire_slave_ctrl.sv
// 3-wire serial slave: decodes R/W + address + data frames from an external
// master and turns them into register write / read strobes.
// Ports:
//   in_clk, in_rst        : system clock (>= 8x bus clock), async active-high reset
//   in_tw_clock, in_tw_cs : bus clock and active-low chip select (asynchronous)
//   io_tw_data            : bidirectional data line
//   out_tw_dir            : 1 = slave listening (line released), 0 = slave driving
//   out_reg_addr          : captured address
//   out_reg_wr_data       : captured write data
//   out_reg_wr/out_reg_rd : one-cycle write / read-request strobes
//   in_reg_rd_data        : read data, valid the cycle after out_reg_rd
//   out_busy              : frame in progress
//   out_frame_err         : one-cycle pulse when a frame is aborted
module threewire_slave_ctrl
    import threewire_slave_ctrl_pkg::*;
#(
    parameter int TWS_ADDRESS_BITS = 10,
    parameter int TWS_DATA_BITS    = 32
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic                        in_tw_clock,
    input  logic                        in_tw_cs,
    inout  wire                         io_tw_data,
    output logic                        out_tw_dir,
    output logic [TWS_ADDRESS_BITS-1:0] out_reg_addr,
    output logic [TWS_DATA_BITS-1:0]    out_reg_wr_data,
    output logic                        out_reg_wr,
    output logic                        out_reg_rd,
    input  logic [TWS_DATA_BITS-1:0]    in_reg_rd_data,
    output logic                        out_busy,
    output logic                        out_frame_err
);

    localparam int A_W      = TWS_ADDRESS_BITS;
    localparam int D_W      = TWS_DATA_BITS;
    localparam int CNT_RAW  = tw_clog2(tw_max(A_W, D_W));
    localparam int CNT_W    = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(A_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(D_W - 1);
    localparam logic [2:0] SYNC_PRESET = {TW_DATA_IDLE, TW_CS_IDLE, TW_CLOCK_IDLE};

    // ---------------- input synchronizers: [0] clock, [1] cs, [2] data
    logic [2:0] raw_bus;
    logic [2:0] sync_bus;
    logic [2:0] rise_bus;
    logic [2:0] fall_bus;

    assign raw_bus = {io_tw_data, in_tw_cs, in_tw_clock};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            threewire_sync_edge #(
                .RESET_VAL (SYNC_PRESET[gi])
            ) u_sync (
                .clk  (in_clk),
                .rst  (in_rst),
                .raw  (raw_bus[gi]),
                .sync (sync_bus[gi]),
                .rise (rise_bus[gi]),
                .fall (fall_bus[gi])
            );
        end
    endgenerate

    logic tw_rise;
    logic tw_fall;
    logic cs_high;
    logic cs_fall;
    logic tw_bit;

    assign tw_rise = rise_bus[0];
    assign tw_fall = fall_bus[0];
    assign cs_high = sync_bus[1];
    assign cs_fall = fall_bus[1];
    assign tw_bit  = sync_bus[2];

    // Edges of these wires carry no meaning for the protocol.
    logic unused_edges;
    assign unused_edges = &{1'b0, sync_bus[0], rise_bus[2:1], fall_bus[2]};

    // ---------------- FSM and datapath
    tw_state_t        state_reg,      state_next;
    logic [CNT_W-1:0] bit_cnt_reg,    bit_cnt_next;
    logic             rw_reg,         rw_next;
    logic [A_W-1:0]   addr_shift_reg, addr_shift_next;
    logic [D_W-1:0]   data_shift_reg, data_shift_next;
    logic [A_W-1:0]   reg_addr_reg,   reg_addr_next;
    logic [D_W-1:0]   wr_data_reg,    wr_data_next;
    logic             wr_pend_reg,    wr_pend_next;
    logic             wr_reg,         wr_next;
    logic             rd_reg,         rd_next;
    logic             rd_latch_reg,   rd_latch_next;
    logic             tw_dir_reg,     tw_dir_next;
    logic             frame_err_reg,  frame_err_next;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg      <= TW_IDLE;
            bit_cnt_reg    <= '0;
            rw_reg         <= 1'b0;
            addr_shift_reg <= '0;
            data_shift_reg <= '0;
            reg_addr_reg   <= '0;
            wr_data_reg    <= '0;
            wr_pend_reg    <= 1'b0;
            wr_reg         <= 1'b0;
            rd_reg         <= 1'b0;
            rd_latch_reg   <= 1'b0;
            tw_dir_reg     <= 1'b1;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            rw_reg         <= rw_next;
            addr_shift_reg <= addr_shift_next;
            data_shift_reg <= data_shift_next;
            reg_addr_reg   <= reg_addr_next;
            wr_data_reg    <= wr_data_next;
            wr_pend_reg    <= wr_pend_next;
            wr_reg         <= wr_next;
            rd_reg         <= rd_next;
            rd_latch_reg   <= rd_latch_next;
            tw_dir_reg     <= tw_dir_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        rw_next         = rw_reg;
        addr_shift_next = addr_shift_reg;
        data_shift_next = data_shift_reg;
        reg_addr_next   = reg_addr_reg;
        wr_data_next    = wr_data_reg;
        wr_pend_next    = 1'b0;
        wr_next         = wr_pend_reg;   // write strobe trails the data update by one cycle
        rd_next         = 1'b0;
        rd_latch_next   = rd_reg;        // read data arrives the cycle after the strobe
        tw_dir_next     = tw_dir_reg;
        frame_err_next  = 1'b0;

        if (rd_latch_reg) begin
            data_shift_next = in_reg_rd_data;
        end

        // CS going high mid-frame wins over any bus edge seen in the same cycle.
        if (cs_high && (state_reg != TW_IDLE) && (state_reg != TW_DONE)) begin
            state_next     = TW_IDLE;
            tw_dir_next    = 1'b1;
            frame_err_next = 1'b1;
        end else begin
            unique case (state_reg)
                TW_IDLE: begin
                    if (cs_fall) begin
                        state_next = TW_RW;
                    end
                end
                TW_RW: begin
                    if (tw_rise) begin
                        rw_next      = tw_bit;
                        bit_cnt_next = ADDR_LAST;
                        state_next   = TW_ADDR;
                    end
                end
                TW_ADDR: begin
                    if (tw_rise) begin
                        addr_shift_next = {addr_shift_reg[A_W-2:0], tw_bit};
                        if (bit_cnt_reg == '0) begin
                            reg_addr_next = {addr_shift_reg[A_W-2:0], tw_bit};
                            if (rw_reg == TW_BIT_WRITE) begin
                                bit_cnt_next = DATA_LAST;
                                state_next   = TW_WR_DATA;
                            end else begin
                                rd_next      = 1'b1;
                                bit_cnt_next = DATA_LAST;
                                state_next   = TW_TURNAROUND;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 1'b1;
                        end
                    end
                end
                TW_WR_DATA: begin
                    if (tw_rise) begin
                        data_shift_next = {data_shift_reg[D_W-2:0], tw_bit};
                        if (bit_cnt_reg == '0) begin
                            wr_data_next = {data_shift_reg[D_W-2:0], tw_bit};
                            wr_pend_next = 1'b1;
                            state_next   = TW_DONE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 1'b1;
                        end
                    end
                end
                TW_TURNAROUND: begin
                    // The MSB is already at the top of the shift register.
                    if (tw_fall) begin
                        tw_dir_next = 1'b0;
                        state_next  = TW_RD_DATA;
                    end
                end
                TW_RD_DATA: begin
                    if (tw_fall) begin
                        if (bit_cnt_reg == '0) begin
                            tw_dir_next = 1'b1;
                            state_next  = TW_DONE;
                        end else begin
                            data_shift_next = {data_shift_reg[D_W-2:0], 1'b0};
                            bit_cnt_next    = bit_cnt_reg - 1'b1;
                        end
                    end
                end
                TW_DONE: begin
                    if (cs_high) begin
                        state_next = TW_IDLE;
                    end
                end
                default: begin
                    state_next  = TW_IDLE;
                    tw_dir_next = 1'b1;
                end
            endcase
        end
    end

    assign io_tw_data      = tw_dir_reg ? 1'bz : data_shift_reg[D_W-1];
    assign out_tw_dir      = tw_dir_reg;
    assign out_reg_addr    = reg_addr_reg;
    assign out_reg_wr_data = wr_data_reg;
    assign out_reg_wr      = wr_reg;
    assign out_reg_rd      = rd_reg;
    assign out_busy        = (state_reg != TW_IDLE);
    assign out_frame_err   = frame_err_reg;

endmodule

// File: tb/tb_threewire_slave_ctrl.sv
// Bench for threewire_slave_ctrl: a bus-master model drives frames at an
// exact 8:1 clock ratio; expected strobes and master read captures are queued
// as frames are issued and checked by independent monitor processes.
module tb_threewire_slave_ctrl;

    localparam int A_W = 10;
    localparam int D_W = 32;
    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int             kind;
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
    } exp_t;

    logic           in_clk = 1'b0;
    logic           in_rst;
    logic           in_tw_clock;
    logic           in_tw_cs;
    wire            io_tw_data;
    logic           out_tw_dir;
    logic [A_W-1:0] out_reg_addr;
    logic [D_W-1:0] out_reg_wr_data;
    logic           out_reg_wr;
    logic           out_reg_rd;
    logic [D_W-1:0] in_reg_rd_data = '0;
    logic           out_busy;
    logic           out_frame_err;

    logic           m_en;
    logic           m_bit;
    logic [D_W-1:0] rd_value = '0;
    logic [D_W-1:0] cap_word;
    event           cap_ev;

    exp_t           exp_q[$];
    logic [D_W-1:0] cap_q[$];

    int total = 0;
    int bad   = 0;

    assign io_tw_data = m_en ? m_bit : 1'bz;

    always #5 in_clk = ~in_clk;

    // Register file model: read data valid the cycle after the strobe.
    always @(posedge in_clk) begin
        in_reg_rd_data <= out_reg_rd ? rd_value : '0;
    end

    threewire_slave_ctrl #(
        .TWS_ADDRESS_BITS (A_W),
        .TWS_DATA_BITS    (D_W)
    ) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_tw_clock     (in_tw_clock),
        .in_tw_cs        (in_tw_cs),
        .io_tw_data      (io_tw_data),
        .out_tw_dir      (out_tw_dir),
        .out_reg_addr    (out_reg_addr),
        .out_reg_wr_data (out_reg_wr_data),
        .out_reg_wr      (out_reg_wr),
        .out_reg_rd      (out_reg_rd),
        .in_reg_rd_data  (in_reg_rd_data),
        .out_busy        (out_busy),
        .out_frame_err   (out_frame_err)
    );

    task automatic check(input string name, input logic [D_W-1:0] act, input logic [D_W-1:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- monitors
    task automatic check_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL unexpected_event: got kind %0d, required none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", D_W'(kind), D_W'(e.kind));
            if (kind != K_ERR) check("event_addr", D_W'(out_reg_addr), D_W'(e.addr));
            if (kind == K_WR)  check("event_wr_data", out_reg_wr_data, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge in_clk);
            if (out_reg_wr) begin
                $display("wr  addr=%h data=%h", out_reg_addr, out_reg_wr_data);
                check_event(K_WR);
            end
            if (out_reg_rd) begin
                $display("rd  addr=%h", out_reg_addr);
                check_event(K_RD);
            end
            if (out_frame_err) begin
                $display("err frame aborted");
                check_event(K_ERR);
            end
        end
    end

    initial begin
        logic [D_W-1:0] want;
        forever begin
            @(cap_ev);
            $display("cap data=%h", cap_word);
            if (cap_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_capture: got %h, required none", cap_word);
            end else begin
                want = cap_q.pop_front();
                check("master_capture", cap_word, want);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- bus master model (8 system clocks per bus period)
    task automatic half_period();
        repeat (4) @(negedge in_clk);
    endtask

    task automatic send_bit(input logic b);
        in_tw_clock = 1'b0;
        m_en        = 1'b1;
        m_bit       = b;
        half_period();
        in_tw_clock = 1'b1;
        half_period();
    endtask

    task automatic end_frame();
        half_period();
        in_tw_cs = 1'b1;
        half_period();
        half_period();
    endtask

    task automatic write_frame(input logic [A_W-1:0] addr, input logic [D_W-1:0] data);
        exp_q.push_back('{K_WR, addr, data});
        in_tw_cs = 1'b0;
        half_period();
        send_bit(1'b1);
        for (int i = A_W - 1; i >= 0; i--) send_bit(addr[i]);
        check("busy_mid_write", D_W'(out_busy), D_W'(1));
        for (int i = D_W - 1; i >= 0; i--) send_bit(data[i]);
        in_tw_clock = 1'b0;
        m_en        = 1'b0;
        end_frame();
    endtask

    task automatic read_frame(input logic [A_W-1:0] addr, input logic [D_W-1:0] value, input int rst_bit);
        logic [D_W-1:0] cap;
        cap      = '0;
        rd_value = value;
        exp_q.push_back('{K_RD, addr, '0});
        if (rst_bit < 0) cap_q.push_back(value);
        in_tw_cs = 1'b0;
        half_period();
        send_bit(1'b0);
        for (int i = A_W - 1; i >= 0; i--) send_bit(addr[i]);
        check("dir_before_turnaround", D_W'(out_tw_dir), D_W'(1));
        in_tw_clock = 1'b0;     // turnaround falling edge
        m_en        = 1'b0;
        for (int i = D_W - 1; i >= 0; i--) begin
            half_period();
            if (i == rst_bit) begin
                check("dir_driving_before_reset", D_W'(out_tw_dir), D_W'(0));
                in_rst      = 1'b1;
                in_tw_cs    = 1'b1;
                in_tw_clock = 1'b0;
                #1;
                check("dir_on_reset", D_W'(out_tw_dir), D_W'(1));
                check("busy_on_reset", D_W'(out_busy), D_W'(0));
                repeat (3) @(negedge in_clk);
                in_rst = 1'b0;
                half_period();
                return;
            end
            cap[i]      = io_tw_data;
            in_tw_clock = 1'b1;
            half_period();
            in_tw_clock = 1'b0;
        end
        end_frame();
        check("dir_after_cs_high", D_W'(out_tw_dir), D_W'(1));
        cap_word = cap;
        ->cap_ev;
    endtask

    // ---------------- directed sequence
    initial begin
        in_rst      = 1'b1;
        in_tw_cs    = 1'b1;
        in_tw_clock = 1'b0;
        m_en        = 1'b0;
        m_bit       = 1'b0;
        repeat (3) @(negedge in_clk);
        #1;
        check("rst_dir", D_W'(out_tw_dir), D_W'(1));
        check("rst_busy", D_W'(out_busy), D_W'(0));
        check("rst_addr", D_W'(out_reg_addr), D_W'(0));
        check("rst_wr_data", out_reg_wr_data, '0);
        check("rst_wr", D_W'(out_reg_wr), D_W'(0));
        check("rst_rd", D_W'(out_reg_rd), D_W'(0));
        check("rst_err", D_W'(out_frame_err), D_W'(0));
        @(negedge in_clk);
        in_rst = 1'b0;
        repeat (4) @(negedge in_clk);

        // Plain write and read.
        write_frame(10'h155, 32'hDEADBEEF);
        read_frame(10'h2AA, 32'h12345678, -1);

        // Abort after 5 address bits, then a full write.
        exp_q.push_back('{K_ERR, '0, '0});
        in_tw_cs = 1'b0;
        half_period();
        send_bit(1'b1);
        for (int i = A_W - 1; i >= A_W - 5; i--) send_bit(1'b1);
        in_tw_clock = 1'b0;
        m_en        = 1'b0;
        end_frame();
        check("busy_after_abort", D_W'(out_busy), D_W'(0));
        write_frame(10'h0F0, 32'hA5A55A5A);

        // Reset while the slave drives bit 20, then a clean read.
        read_frame(10'h013, 32'hCAFEF00D, 20);
        read_frame(10'h013, 32'h0BADF00D, -1);

        // Back-to-back frames, CS high for one bus period between them.
        write_frame(10'h3FF, 32'h80000001);
        read_frame(10'h200, 32'h7FFFFFFE, -1);

        repeat (20) @(negedge in_clk);
        check("events_pending", D_W'(exp_q.size()), D_W'(0));
        check("captures_pending", D_W'(cap_q.size()), D_W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
